// File: rtl/shift_rows_unit.sv
// AES/Rijndael ShiftRows for NB = 4, 6 or 8 columns, selectable forward/inverse
// per state, followed by a small output FIFO with valid/ready on both sides.
module shift_rows_unit #(
    parameter int NB         = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int W         = 32 * NB,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_inv,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_inv,
    output logic [LW-1:0] level
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (!(NB == 4 || NB == 6 || NB == 8) || FIFO_DEPTH < 2 || FIFO_DEPTH > 8) begin : g_bad_params
        $error("shift_rows_unit: illegal NB or FIFO_DEPTH");
    end

    // Handshake: a state moves on a rising edge where valid and ready are both 1;
    // in_ready looks only at the entry count, never at out_ready.
    logic [W-1:0]  fwd_state;
    logic [W-1:0]  inv_state;
    logic [W-1:0]  shifted;
    logic [W:0]    mem [FIFO_DEPTH];
    logic [W:0]    head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ready_en;
    logic          push;
    logic          pop;

    // Byte k = 4*c + r sits at bits [W-1-8k -: 8]; every index here is a constant.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF   = (NB == 8 && r >= 2) ? r + 1 : r;
            localparam int FWD_C = (c + OFF) % NB;
            localparam int INV_C = (c + NB - OFF) % NB;
            assign fwd_state[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*FWD_C+r) -: 8];
            assign inv_state[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*INV_C+r) -: 8];
        end
    end

    assign shifted   = in_inv ? inv_state : fwd_state;
    assign in_ready  = ready_en && (level < LW'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Gating the head with out_valid keeps stale or reset-era entries off the bus.
    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[W-1:0] : '0;
    assign out_inv  = out_valid & head[W];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= next_ptr(wr_ptr);
                if (pop)  rd_ptr <= next_ptr(rd_ptr);
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= {in_inv, shifted};
    end

endmodule
